// File: rtl/net_resolve_fifo.sv
// net_resolve_fifo: resolves CH 4-state drivers of W bits per net kind
// (tri / triand / trior), queues each accepted result in a DEPTH-entry FIFO
// and counts accepted results that contain at least one x bit.
module net_resolve_fifo #(
  parameter int W     = 4,
  parameter int CH    = 3,
  parameter int KIND  = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH-1:0]            drv_en,
  input  logic [CH*W-1:0]          drv_val,
  input  logic [CH*W-1:0]          drv_unk,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_val,
  output logic [W-1:0]             out_unk,
  output logic                     out_xflag,
  output logic [CNT_W-1:0]         conflict_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * W + 1;

  // Parameter sanity: reject unsupported configurations at elaboration.
  if (KIND < 0 || KIND > 2) begin : g_kind_err
    $error("net_resolve_fifo: KIND must be 0 (tri), 1 (triand) or 2 (trior)");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
    $error("net_resolve_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (CH < 2) begin : g_ch_err
    $error("net_resolve_fifo: CH must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Per-bit resolution. Encoding {unk,val}: 00=0, 01=1, 10=z, 11=x.
  // ---------------------------------------------------------------------------
  logic [W-1:0] res_val;
  logic [W-1:0] res_unk;
  logic         res_x;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic       has0;
      logic       has1;
      logic       hasx;
      logic [1:0] res;

      // Collect which logic levels the enabled drivers put on this bit.
      always_comb begin
        has0 = 1'b0;
        has1 = 1'b0;
        hasx = 1'b0;
        for (int c = 0; c < CH; c++) begin
          if (drv_en[c]) begin
            case ({drv_unk[c*W+gi], drv_val[c*W+gi]})
              2'b00:   has0 = 1'b1;
              2'b01:   has1 = 1'b1;
              2'b11:   hasx = 1'b1;
              default: ;
            endcase
          end
        end
      end

      // Apply the net-kind priority to the collected levels.
      always_comb begin
        res = 2'b10;
        if (KIND == 1) begin
          if (has0)      res = 2'b00;
          else if (hasx) res = 2'b11;
          else if (has1) res = 2'b01;
        end else if (KIND == 2) begin
          if (has1)      res = 2'b01;
          else if (hasx) res = 2'b11;
          else if (has0) res = 2'b00;
        end else begin
          if (hasx || (has0 && has1)) res = 2'b11;
          else if (has1)              res = 2'b01;
          else if (has0)              res = 2'b00;
        end
      end

      assign res_unk[gi] = res[1];
      assign res_val[gi] = res[0];
    end
  endgenerate

  assign res_x = |(res_unk & res_val);

  // ---------------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;

  assign in_ready  = (level_reg < LW'(DEPTH));
  assign out_valid = (level_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage array has no reset; stale contents are hidden by level.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= {res_x, res_unk, res_val};
    end
  end

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Saturating count of accepted results carrying an x bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (push && res_x && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign head         = mem[rd_ptr_reg];
  assign out_val      = head[W-1:0];
  assign out_unk      = head[2*W-1:W];
  assign out_xflag    = head[2*W];
  assign conflict_cnt = cnt_reg;
  assign level        = level_reg;

endmodule

// File: tb/tb_net_resolve_fifo.sv
// tb_net_resolve_fifo: directed checks of net_resolve_fifo. Three instances
// (tri / triand / trior) share the same stimulus; the tri instance uses a
// 2-bit conflict counter so saturation is reached quickly.
module tb_net_resolve_fifo;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  drv_en;
  logic [11:0] drv_val;
  logic [11:0] drv_unk;

  logic       t_in_ready, t_out_valid, t_out_xflag;
  logic [3:0] t_out_val, t_out_unk;
  logic [1:0] t_cnt;
  logic [2:0] t_level;

  logic       a_in_ready, a_out_valid, a_out_xflag;
  logic [3:0] a_out_val, a_out_unk;
  logic [7:0] a_cnt;
  logic [2:0] a_level;

  logic       o_in_ready, o_out_valid, o_out_xflag;
  logic [3:0] o_out_val, o_out_unk;
  logic [7:0] o_cnt;
  logic [2:0] o_level;

  int n_checks = 0;
  int n_fail   = 0;

  net_resolve_fifo #(.W(4), .CH(3), .KIND(0), .DEPTH(4), .CNT_W(2)) u_tri (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
    .drv_en(drv_en), .drv_val(drv_val), .drv_unk(drv_unk),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_val(t_out_val),
    .out_unk(t_out_unk), .out_xflag(t_out_xflag), .conflict_cnt(t_cnt),
    .level(t_level)
  );

  net_resolve_fifo #(.W(4), .CH(3), .KIND(1), .DEPTH(4), .CNT_W(8)) u_and (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .drv_en(drv_en), .drv_val(drv_val), .drv_unk(drv_unk),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_val(a_out_val),
    .out_unk(a_out_unk), .out_xflag(a_out_xflag), .conflict_cnt(a_cnt),
    .level(a_level)
  );

  net_resolve_fifo #(.W(4), .CH(3), .KIND(2), .DEPTH(4), .CNT_W(8)) u_or (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready),
    .drv_en(drv_en), .drv_val(drv_val), .drv_unk(drv_unk),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_val(o_out_val),
    .out_unk(o_out_unk), .out_xflag(o_out_xflag), .conflict_cnt(o_cnt),
    .level(o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_drv(input logic [2:0] en, input logic [11:0] v, input logic [11:0] u);
    drv_en  = en;
    drv_val = v;
    drv_unk = u;
  endtask

  task automatic push(input logic [2:0] en, input logic [11:0] v, input logic [11:0] u);
    set_drv(en, v, u);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("push en=%b val=%h unk=%h -> level=%0d", en, v, u, a_level);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("pop -> level=%0d", a_level);
  endtask

  // Expected head of each instance: {xflag, unk, val}
  task automatic chk_head(input string tag,
                          input logic [8:0] t_exp, input logic [8:0] a_exp,
                          input logic [8:0] o_exp);
    chk({tag, ".tri_head"}, {23'd0, t_out_xflag, t_out_unk, t_out_val}, {23'd0, t_exp});
    chk({tag, ".and_head"}, {23'd0, a_out_xflag, a_out_unk, a_out_val}, {23'd0, a_exp});
    chk({tag, ".or_head"},  {23'd0, o_out_xflag, o_out_unk, o_out_val}, {23'd0, o_exp});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_drv(3'b000, 12'h000, 12'h000);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.level",     a_level,     3'd0);
    chk("rst.out_valid", a_out_valid, 1'b0);
    chk("rst.in_ready",  a_in_ready,  1'b1);
    chk("rst.cnt_and",   a_cnt,       8'd0);
    chk("rst.cnt_tri",   t_cnt,       2'd0);

    // 1: drivers 1111 / 1010 / 1111, all enabled
    push(3'b111, 12'b1111_1010_1111, 12'h000);
    chk("t1.out_valid", a_out_valid, 1'b1);
    chk("t1.level",     a_level,     3'd1);
    chk_head("t1", {1'b1, 4'b0101, 4'b1111}, {1'b0, 4'b0000, 4'b1010},
             {1'b0, 4'b0000, 4'b1111});
    chk("t1.cnt_and", a_cnt, 8'd0);
    chk("t1.cnt_tri", t_cnt, 2'd1);
    pop1();
    chk("t1.level_after_pop", a_level,     3'd0);
    chk("t1.valid_after_pop", a_out_valid, 1'b0);

    // 2: drv0=0001, drv1=0011, drv2 disabled
    push(3'b011, 12'b0110_0011_0001, 12'h000);
    chk_head("t2", {1'b1, 4'b0010, 4'b0011}, {1'b0, 4'b0000, 4'b0001},
             {1'b0, 4'b0000, 4'b0011});
    chk("t2.cnt_tri", t_cnt, 2'd2);
    chk("t2.cnt_or",  o_cnt, 8'd0);
    pop1();

    // 3a: no driver enabled -> all z
    push(3'b000, 12'b1010_0101_1100, 12'h000);
    chk_head("t3a", {1'b0, 4'b1111, 4'b0000}, {1'b0, 4'b1111, 4'b0000},
             {1'b0, 4'b1111, 4'b0000});
    pop1();

    // 3b: only drv0, x on bit0, zeros elsewhere
    push(3'b001, 12'b1111_1111_0001, 12'b1010_0000_0001);
    chk_head("t3b", {1'b1, 4'b0001, 4'b0001}, {1'b1, 4'b0001, 4'b0001},
             {1'b1, 4'b0001, 4'b0001});
    chk("t3b.cnt_tri", t_cnt, 2'd3);
    chk("t3b.cnt_and", a_cnt, 8'd1);
    chk("t3b.cnt_or",  o_cnt, 8'd1);
    pop1();

    // 4: fill with in_valid held high, no consumer
    for (int k = 0; k < 5; k++) begin
      set_drv(3'b111, {8'hFF, 4'(k + 1)}, 12'h000);
      in_valid = 1'b1;
      tick();
      $display("fill k=%0d in_ready=%b level=%0d", k, a_in_ready, a_level);
    end
    chk("t4.level_full",    a_level,    3'd4);
    chk("t4.in_ready_full", a_in_ready, 1'b0);
    chk("t4.tri_level",     t_level,    3'd4);
    chk_head("t4.h0", {1'b1, 4'b1110, 4'b1111}, {1'b0, 4'b0000, 4'b0001},
             {1'b0, 4'b0000, 4'b1111});
    // Consumer starts while snapshot 5 is still offered
    out_ready = 1'b1;
    tick();
    chk("t4.level_pop_only", a_level,    3'd3);
    chk("t4.in_ready_open",  a_in_ready, 1'b1);
    chk("t4.head1",          a_out_val,  4'b0010);
    tick();
    chk("t4.level_push_pop", a_level,    3'd3);
    chk("t4.head2",          a_out_val,  4'b0011);
    in_valid = 1'b0;
    tick();
    chk("t4.level_drain2",   a_level,    3'd2);
    chk("t4.head3",          a_out_val,  4'b0100);
    tick();
    chk("t4.level_drain1",   a_level,    3'd1);
    chk("t4.head4",          a_out_val,  4'b0101);
    tick();
    chk("t4.level_empty",    a_level,    3'd0);
    chk("t4.valid_empty",    a_out_valid, 1'b0);
    out_ready = 1'b0;

    // 5: five more x results went into tri; 2-bit counter holds at 3
    chk("t5.cnt_tri_sat", t_cnt, 2'd3);
    chk("t5.cnt_and",     a_cnt, 8'd1);
    chk("t5.cnt_or",      o_cnt, 8'd1);

    // 6: reset while pushing with three entries queued
    push(3'b111, 12'h000, 12'h000);
    push(3'b111, 12'h000, 12'h000);
    push(3'b111, 12'h000, 12'h000);
    chk("t6.level_pre", a_level, 3'd3);
    set_drv(3'b111, 12'hFFF, 12'h000);
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    $display("reset pulse -> level=%0d out_valid=%b", a_level, a_out_valid);
    chk("t6.level",     a_level,     3'd0);
    chk("t6.out_valid", a_out_valid, 1'b0);
    chk("t6.in_ready",  a_in_ready,  1'b1);
    chk("t6.cnt_tri",   t_cnt,       2'd0);
    chk("t6.cnt_and",   a_cnt,       8'd0);
    chk("t6.cnt_or",    o_cnt,       8'd0);
    tick();
    chk("t6.level_hold", a_level, 3'd0);
    push(3'b111, 12'b1100_1100_1100, 12'h000);
    chk("t6.level_new", a_level, 3'd1);
    chk_head("t6.new", {1'b0, 4'b0000, 4'b1100}, {1'b0, 4'b0000, 4'b1100},
             {1'b0, 4'b0000, 4'b1100});
    pop1();
    chk("t6.level_end", a_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
